// File: rtl/bsg_swap_sched_pkg.sv
// Shared types for the lane-swap scheduler: swap modes and packet FSM states.
package bsg_swap_sched_pkg;

    typedef enum logic [1:0] {
        e_swap_straight = 2'd0,
        e_swap_cross    = 2'd1,
        e_swap_alt_beat = 2'd2,
        e_swap_alt_pkt  = 2'd3
    } bsg_swap_mode_e;

    typedef enum logic {
        e_idle = 1'b0,
        e_busy = 1'b1
    } bsg_swap_state_e;

endpackage

// File: rtl/bsg_swap.sv
// Lane exchange: swaps the upper and lower width_p halves of a beat when swap_i is set.
module bsg_swap #(
    parameter int width_p = 32
) (
    input  logic                 swap_i,
    input  logic [2*width_p-1:0] data_i,
    output logic [2*width_p-1:0] data_o
);

    assign data_o = swap_i ? {data_i[width_p-1:0], data_i[2*width_p-1:width_p]} : data_i;

endmodule

// File: rtl/bsg_swap_sched.sv
// Packet-aware lane-swap scheduler with a single registered output stage.
module bsg_swap_sched
    import bsg_swap_sched_pkg::*;
#(
    parameter int width_p     = 32,
    parameter int len_width_p = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   v_i,
    input  logic [2*width_p-1:0]   data_i,
    output logic                   ready_o,
    input  logic [1:0]             mode_i,
    input  logic [len_width_p-1:0] len_i,
    output logic                   v_o,
    output logic [2*width_p-1:0]   data_o,
    output logic                   swap_o,
    output logic                   last_o,
    input  logic                   ready_i
);

    bsg_swap_state_e          state_r, state_n;
    bsg_swap_mode_e           mode_r, eff_mode;
    logic [len_width_p-1:0]   len_r, eff_len, cnt_r;
    logic                     swap_r, beat_swap, is_last, accept;
    logic [2*width_p-1:0]     swapped;

    assign ready_o = ~v_o | ready_i;
    assign accept  = v_i & ready_o;

    // Packet attributes come straight from the inputs only at a packet boundary.
    assign eff_mode = (state_r == e_idle) ? bsg_swap_mode_e'(mode_i) : mode_r;
    assign eff_len  = (state_r == e_idle) ? len_i : len_r;
    assign is_last  = (cnt_r == eff_len);

    always_comb begin
        beat_swap = swap_r;
        case (eff_mode)
            e_swap_straight: beat_swap = 1'b0;
            e_swap_cross:    beat_swap = 1'b1;
            default:         beat_swap = swap_r;
        endcase
    end

    always_comb begin
        state_n = state_r;
        if (accept)
            state_n = is_last ? e_idle : e_busy;
    end

    bsg_swap #(.width_p(width_p)) swap_u (
        .swap_i (beat_swap),
        .data_i (data_i),
        .data_o (swapped)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= e_idle;
            cnt_r   <= '0;
            swap_r  <= 1'b0;
            mode_r  <= e_swap_straight;
            len_r   <= '0;
        end else begin
            state_r <= state_n;
            if (accept) begin
                if (state_r == e_idle) begin
                    mode_r <= bsg_swap_mode_e'(mode_i);
                    len_r  <= len_i;
                end
                cnt_r <= is_last ? '0 : cnt_r + 1'b1;
                // Held through straight/cross so a later alternating packet resumes the phase.
                if ((eff_mode == e_swap_alt_beat) || (eff_mode == e_swap_alt_pkt && is_last))
                    swap_r <= ~swap_r;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            v_o    <= 1'b0;
            data_o <= '0;
            swap_o <= 1'b0;
            last_o <= 1'b0;
        end else if (accept) begin
            v_o    <= 1'b1;
            data_o <= swapped;
            swap_o <= beat_swap;
            last_o <= is_last;
        end else if (ready_i) begin
            v_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bsg_swap_sched.sv
// Randomized + directed bench for bsg_swap_sched against a packet-level reference model.
module tb_bsg_swap_sched;

    localparam int W = 32;
    localparam int L = 8;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          v_i;
    logic [2*W-1:0] data_i;
    logic          ready_o;
    logic [1:0]    mode_i;
    logic [L-1:0]  len_i;
    logic          v_o;
    logic [2*W-1:0] data_o;
    logic          swap_o;
    logic          last_o;
    logic          ready_i;

    int total = 0;
    int bad   = 0;

    // Reference: expected output register plus packet progress.
    logic           m_v, m_swap, m_last, m_phase;
    logic [2*W-1:0] m_data;
    int             m_beat, m_mode, m_len;

    always #5 clk_i = ~clk_i;

    bsg_swap_sched #(.width_p(W), .len_width_p(L)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
        .mode_i(mode_i), .len_i(len_i), .v_o(v_o), .data_o(data_o), .swap_o(swap_o),
        .last_o(last_o), .ready_i(ready_i)
    );

    task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_v = 0; m_swap = 0; m_last = 0; m_phase = 0; m_data = '0;
        m_beat = 0; m_mode = 0; m_len = 0;
    endtask

    task automatic check_outs(input string tag);
        check({tag, ".v"},    {63'd0, v_o},    {63'd0, m_v});
        check({tag, ".data"}, data_o,          m_data);
        check({tag, ".swap"}, {63'd0, swap_o}, {63'd0, m_swap});
        check({tag, ".last"}, {63'd0, last_o}, {63'd0, m_last});
    endtask

    // One cycle: drive at negedge, check ready, apply model at posedge, check outputs.
    task automatic step(input string tag, input logic v, input logic [2*W-1:0] d,
                        input int m, input int l, input logic r);
        int  mode, len;
        logic sw, last;
        v_i = v; data_i = d; mode_i = 2'(m); len_i = L'(l); ready_i = r;
        #1 check({tag, ".rdy"}, {63'd0, ready_o}, {63'd0, (!m_v || r)});
        @(posedge clk_i);
        if (v && (!m_v || r)) begin
            if (m_beat == 0) begin m_mode = m; m_len = l; end
            mode = m_mode; len = m_len;
            last = (m_beat == len);
            sw   = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : m_phase;
            m_data = sw ? {d[W-1:0], d[2*W-1:W]} : d;
            m_v = 1; m_swap = sw; m_last = last;
            if (mode == 2 || (mode == 3 && last)) m_phase = ~m_phase;
            m_beat = last ? 0 : m_beat + 1;
        end else if (r) begin
            m_v = 0;
        end
        @(negedge clk_i);
        check_outs(tag);
    endtask

    function automatic logic [2*W-1:0] rnd();
        return {$urandom, $urandom};
    endfunction

    initial begin
        v_i = 0; data_i = '0; mode_i = 0; len_i = 0; ready_i = 0;
        reset_i = 1;
        model_reset();
        #1;
        check("rst.rdy", {63'd0, ready_o}, 64'd1);
        check_outs("rst");
        @(negedge clk_i);
        reset_i = 0;

        // Crossed single-beat packet.
        step("cross", 1, 64'h11111111_22222222, 1, 0, 1);
        check("cross.const", data_o, 64'h22222222_11111111);
        check("cross.sl", {62'd0, swap_o, last_o}, 64'd3);
        step("idle", 0, '0, 0, 0, 1);

        // Alternate per beat, 4 beats back to back.
        for (int i = 0; i < 4; i++) begin
            step("altb", 1, rnd(), 2, 3, 1);
            check("altb.swap", {63'd0, swap_o}, {63'd0, logic'(i % 2)});
        end
        step("idle", 0, '0, 0, 0, 1);

        // Alternate per packet; mode_i dropped to 0 mid-packet must be ignored.
        for (int i = 0; i < 6; i++)
            step("altp", 1, rnd(), (i % 2) ? 0 : 3, 1, 1);
        step("idle", 0, '0, 0, 0, 1);

        // Backpressure: hold 3 cycles, then drain and load with no bubble.
        step("bp.load", 1, rnd(), 0, 3, 1);
        for (int i = 0; i < 3; i++) step("bp.hold", 1, rnd(), 0, 3, 0);
        step("bp.drain", 1, rnd(), 0, 3, 1);
        check("bp.nobubble", {63'd0, v_o}, 64'd1);
        step("bp.tail", 1, rnd(), 0, 3, 1);
        step("bp.end", 1, rnd(), 0, 3, 1);
        step("idle", 0, '0, 0, 0, 1);

        // Reset mid-packet, immediate effect, then a fresh single-beat packet.
        step("rmp", 1, rnd(), 2, 3, 1);
        step("rmp", 1, rnd(), 2, 3, 1);
        reset_i = 1;
        #1;
        model_reset();
        check("rmp.v", {63'd0, v_o}, 64'd0);
        check("rmp.rdy", {63'd0, ready_o}, 64'd1);
        @(negedge clk_i);
        reset_i = 0;
        step("rmp.new", 1, rnd(), 0, 0, 1);
        check("rmp.last", {63'd0, last_o}, 64'd1);
        step("idle", 0, '0, 0, 0, 1);

        // Longest packet: 256 beats, then next packet starts on the toggled phase.
        for (int i = 0; i < 257; i++) begin
            step("long", 1, rnd(), 3, 255, 1);
            if (i == 254) check("long.notlast", {63'd0, last_o}, 64'd0);
            if (i == 255) check("long.last", {63'd0, last_o}, 64'd1);
        end
        check("long.toggle", {63'd0, swap_o}, 64'd1);
        step("idle", 0, '0, 0, 0, 1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) < 2) begin
                reset_i = 1;
                #1 model_reset();
                check_outs("rnd.rst");
                @(negedge clk_i);
                reset_i = 0;
            end
            step("rnd", logic'($urandom_range(9) < 7), rnd(), $urandom_range(3),
                 ($urandom_range(9) == 0) ? $urandom_range(255) : $urandom_range(3),
                 logic'($urandom_range(9) < 7));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
